uart_tx_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one UART_TX instance between NUM_REQ byte-stream requesters (sample streamer, status reporter, command echo and similar).
- Grants are packet-locked: once a requester wins, it keeps the transmitter until its byte flagged last has been fully sent.
- Issues the transmitter's one-cycle data-valid strobe and tracks the transmitter's active/done outputs.
- A watchdog releases the grant if a requester stalls or the transmitter hangs.

---
 rtl/uart_arb_pkg.sv | 23 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 38 +++
 rtl/uart_tx_arbiter.sv | 161 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding,
// default sizing and a width helper for the round-robin pointer.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } arb_state_t;

  localparam int unsigned DEF_NUM_REQ      = 4;
  localparam int unsigned DEF_TIMEOUT_CLKS = 4096;
  localparam int unsigned DEF_CNT_W        = 13;

  // Ceiling log2, never less than 1 so a pointer always has at least one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
// Ports:
//   valid      in  NUM_REQ  request lines
//   ptr        in  PTR_W    index with highest priority this round
//   win_onehot out NUM_REQ  one-hot winner (zero when no valid)
//   win_idx    out PTR_W    binary index of winner
//   any_valid  out 1        at least one request present
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned PTR_W   = clog2_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win_onehot,
  output logic [PTR_W-1:0]   win_idx,
  output logic               any_valid
);

  // Scan from ptr upward, wrapping; the first valid index wins.
  always_comb begin
    int unsigned c;
    win_onehot = '0;
    win_idx    = '0;
    any_valid  = 1'b0;
    c          = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      c = (32'(ptr) + i) % NUM_REQ;
      if (!any_valid && valid[PTR_W'(c)]) begin
        any_valid              = 1'b1;
        win_idx                = PTR_W'(c);
        win_onehot[PTR_W'(c)]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between NUM_REQ byte streams.
// Round-robin, packet-locked grants; a watchdog frees a stalled grant.
// Ports:
//   i_Clock, i_Rst_n           clock, async active-low reset
//   i_Req_Valid/Byte/Last      per-requester byte stream (byte k at [8k+7:8k])
//   o_Req_Ready                one-cycle accept pulse to the granted requester
//   o_Grant                    one-hot current owner, zero when free
//   o_TX_DV, o_TX_Byte         transmitter strobe and byte
//   i_TX_Active, i_TX_Done     transmitter status
//   o_Busy                     controller not idle
//   o_Timeout                  one-cycle watchdog abort pulse
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ      = DEF_NUM_REQ,
  parameter int unsigned TIMEOUT_CLKS = DEF_TIMEOUT_CLKS,
  parameter int unsigned CNT_W        = DEF_CNT_W
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_n,
  input  logic [NUM_REQ-1:0]   i_Req_Valid,
  input  logic [8*NUM_REQ-1:0] i_Req_Byte,
  input  logic [NUM_REQ-1:0]   i_Req_Last,
  output logic [NUM_REQ-1:0]   o_Req_Ready,
  output logic [NUM_REQ-1:0]   o_Grant,
  output logic                 o_TX_DV,
  output logic [7:0]           o_TX_Byte,
  input  logic                 i_TX_Active,
  input  logic                 i_TX_Done,
  output logic                 o_Busy,
  output logic                 o_Timeout
);

  localparam int unsigned PTR_W = clog2_min1(NUM_REQ);

  arb_state_t         state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   grant_idx;
  logic               last_q;
  logic [CNT_W-1:0]   wdog;
  logic               done_d;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_any;
  logic [7:0]         req_bytes [NUM_REQ];

  logic               done_rise;
  logic               tx_free;
  logic               wdog_term;
  logic [PTR_W-1:0]   ptr_after;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .valid      (i_Req_Valid),
    .ptr        (rr_ptr),
    .win_onehot (pick_onehot),
    .win_idx    (pick_idx),
    .any_valid  (pick_any)
  );

  // Unflatten the byte bus so the granted byte is a simple array read.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_bytes[i] = i_Req_Byte[8*i +: 8];
    end
  end

  // A multi-cycle done counts once: only its rising edge completes a byte.
  assign done_rise = i_TX_Done & ~done_d;
  assign tx_free   = ~i_TX_Active & ~i_TX_Done;
  assign wdog_term = (wdog == CNT_W'(TIMEOUT_CLKS - 1));
  // Next round starts just after the releasing owner.
  assign ptr_after = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  // Arbiter FSM with watchdog; strobes default low every cycle.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      grant_idx   <= '0;
      last_q      <= 1'b0;
      wdog        <= '0;
      done_d      <= 1'b0;
      o_Req_Ready <= '0;
      o_Grant     <= '0;
      o_TX_DV     <= 1'b0;
      o_TX_Byte   <= '0;
      o_Busy      <= 1'b0;
      o_Timeout   <= 1'b0;
    end else begin
      done_d      <= i_TX_Done;
      o_TX_DV     <= 1'b0;
      o_Req_Ready <= '0;
      o_Timeout   <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            o_Grant   <= pick_onehot;
            grant_idx <= pick_idx;
            wdog      <= '0;
            state     <= ST_SEND;
            o_Busy    <= 1'b1;
          end
        end

        ST_SEND: begin
          if (i_Req_Valid[grant_idx] && tx_free) begin
            o_TX_Byte   <= req_bytes[grant_idx];
            o_TX_DV     <= 1'b1;
            o_Req_Ready <= o_Grant;
            last_q      <= i_Req_Last[grant_idx];
            wdog        <= '0;
            state       <= ST_WAIT;
          end else if (wdog_term) begin
            o_Timeout <= 1'b1;
            o_Grant   <= '0;
            rr_ptr    <= ptr_after;
            state     <= ST_IDLE;
            o_Busy    <= 1'b0;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end

        ST_WAIT: begin
          // done_rise takes priority over a coincident watchdog terminal count.
          if (done_rise) begin
            wdog <= '0;
            if (last_q) begin
              o_Grant <= '0;
              rr_ptr  <= ptr_after;
              state   <= ST_IDLE;
              o_Busy  <= 1'b0;
            end else begin
              state <= ST_SEND;
            end
          end else if (wdog_term) begin
            o_Timeout <= 1'b1;
            o_Grant   <= '0;
            rr_ptr    <= ptr_after;
            state     <= ST_IDLE;
            o_Busy    <= 1'b0;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end

        default: begin
          o_Grant <= '0;
          state   <= ST_IDLE;
          o_Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: requester drivers, a UART_TX timing model,
// a queue-based reference model of round-robin packet ordering and a
// scoreboard monitor that checks every DV strobe and timeout.
module tb_uart_tx_arbiter;

  localparam int unsigned NR   = 4;
  localparam int unsigned TO   = 200;
  localparam int unsigned CW   = 9;
  localparam int unsigned CPB  = 8;
  localparam int unsigned BUDG = 4000;

  typedef struct packed {
    logic [7:0] b;
    logic [2:0] r;
  } exp_t;

  logic            clk;
  logic            rst_n;
  logic [NR-1:0]   req_valid;
  logic [8*NR-1:0] req_byte;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   o_Req_Ready;
  logic [NR-1:0]   o_Grant;
  logic            o_TX_DV;
  logic [7:0]      o_TX_Byte;
  logic            tx_active;
  logic            tx_done;
  logic            o_Busy;
  logic            o_Timeout;

  uart_tx_arbiter #(
    .NUM_REQ      (NR),
    .TIMEOUT_CLKS (TO),
    .CNT_W        (CW)
  ) dut (
    .i_Clock     (clk),
    .i_Rst_n     (rst_n),
    .i_Req_Valid (req_valid),
    .i_Req_Byte  (req_byte),
    .i_Req_Last  (req_last),
    .o_Req_Ready (o_Req_Ready),
    .o_Grant     (o_Grant),
    .o_TX_DV     (o_TX_DV),
    .o_TX_Byte   (o_TX_Byte),
    .i_TX_Active (tx_active),
    .i_TX_Done   (tx_done),
    .o_Busy      (o_Busy),
    .o_Timeout   (o_Timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] drv_byte [NR][$];
  bit         drv_last [NR][$];
  logic [7:0] mdl_byte [NR][$];
  bit         mdl_last [NR][$];
  exp_t       sb [$];
  int         mdl_ptr = 0;
  int         rdy_cnt [NR];
  int         exp_to = 0;
  int         dv_count = 0;
  int         dv_cyc = 0;
  int         cyc = 0;
  bit         prev_free = 1'b1;
  bit         hang = 1'b0;
  int         done_hold = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit drv_empty();
    for (int k = 0; k < NR; k++) if (drv_byte[k].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Queue one packet for requester k at both the driver and the model.
  task automatic add_pkt(input int k, input int len, input bit fixed, input logic [7:0] first);
    logic [7:0] b;
    for (int i = 0; i < len; i++) begin
      b = fixed ? first + 8'(i) : 8'($urandom_range(0, 255));
      drv_byte[k].push_back(b);
      drv_last[k].push_back(i == len - 1);
      mdl_byte[k].push_back(b);
      mdl_last[k].push_back(i == len - 1);
    end
  endtask

  // Reference order: repeatedly take the first requester at/after the
  // pointer with pending packets, emit its whole packet, advance past it.
  task automatic plan();
    int   w;
    int   c;
    bit   l;
    exp_t e;
    while (1) begin
      w = -1;
      for (int i = 0; i < NR; i++) begin
        c = (mdl_ptr + i) % NR;
        if (w < 0 && mdl_byte[c].size() > 0) w = c;
      end
      if (w < 0) break;
      do begin
        e.b = mdl_byte[w].pop_front();
        l   = mdl_last[w].pop_front();
        e.r = 3'(w);
        sb.push_back(e);
      end while (!l);
      mdl_ptr = (w + 1) % NR;
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (n < BUDG && !(sb.size() == 0 && exp_to == 0 && !o_Busy &&
                         !tx_active && !tx_done && drv_empty())) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_finished_in_budget"}, 32'(n < BUDG), 32'd1);
    chk({name, "_grant_clear"}, 32'(o_Grant), 32'd0);
  endtask

  // UART_TX model: busy for 10 bit times after DV, then done for done_hold.
  initial begin
    int cnt;
    int dcnt;
    tx_active = 1'b0;
    tx_done   = 1'b0;
    cnt  = 0;
    dcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) tx_done = 1'b0;
      end
      if (tx_active) begin
        cnt--;
        if (cnt == 0) begin
          tx_active = 1'b0;
          if (!hang) begin
            tx_done = 1'b1;
            dcnt    = done_hold;
          end
        end
      end else if (o_TX_DV && !tx_done) begin
        tx_active = 1'b1;
        cnt       = 10 * CPB;
      end
    end
  end

  // Requester drivers: present queue head, pop on ready, abandon on timeout.
  initial begin
    int last_g;
    last_g    = 0;
    req_valid = '0;
    req_byte  = '0;
    req_last  = '0;
    for (int k = 0; k < NR; k++) rdy_cnt[k] = 0;
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < NR; k++) if (o_Grant[k]) last_g = k;
      for (int k = 0; k < NR; k++) begin
        if (o_Req_Ready[k] && drv_byte[k].size() > 0) begin
          void'(drv_byte[k].pop_front());
          void'(drv_last[k].pop_front());
          rdy_cnt[k]++;
        end
      end
      if (o_Timeout) begin
        bit l;
        l = 1'b0;
        while (!l && drv_byte[last_g].size() > 0) begin
          void'(drv_byte[last_g].pop_front());
          l = drv_last[last_g].pop_front();
        end
      end
      for (int k = 0; k < NR; k++) begin
        req_valid[k] = drv_byte[k].size() > 0;
        req_byte[8*k +: 8] = req_valid[k] ? drv_byte[k][0] : 8'h00;
        req_last[k] = req_valid[k] ? drv_last[k][0] : 1'b0;
      end
    end
  end

  // Scoreboard monitor, sampled on the inactive edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        chk("grant_onehot0", 32'($onehot0(o_Grant)), 32'd1);
        chk("busy_matches_grant", 32'(o_Busy), 32'(o_Grant != '0));
        chk("ready_only_to_owner_with_dv", 32'(o_Req_Ready), 32'(o_TX_DV ? o_Grant : '0));
        if (o_TX_DV) begin
          dv_count++;
          dv_cyc = cyc;
          chk("dv_only_when_tx_free", 32'(prev_free), 32'd1);
          if (sb.size() == 0) begin
            chk("unexpected_dv_byte", 32'(o_TX_Byte), 32'hFFFF_FFFF);
          end else begin
            e = sb.pop_front();
            chk("tx_byte", 32'(o_TX_Byte), 32'(e.b));
            chk("grant_owner", 32'(o_Grant), 32'(4'b0001 << e.r));
          end
        end
        if (o_Timeout) begin
          chk("timeout_expected", 32'(exp_to), 32'd1);
          chk("timeout_delay_after_dv", 32'(cyc - dv_cyc), 32'(TO));
          chk("timeout_grant_clear", 32'(o_Grant), 32'd0);
          exp_to = 0;
        end
      end
      prev_free = !tx_active && !tx_done;
    end
  end

  initial begin
    int base;
    int n;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_grant", 32'(o_Grant), 32'd0);
    chk("reset_dv", 32'(o_TX_DV), 32'd0);
    chk("reset_busy", 32'(o_Busy), 32'd0);
    chk("reset_ready", 32'(o_Req_Ready), 32'd0);
    chk("reset_txbyte", 32'(o_TX_Byte), 32'd0);
    rst_n = 1'b1;

    // Req0 packet 41,42,43.
    done_hold = 1;
    add_pkt(0, 3, 1'b1, 8'h41);
    plan();
    wait_idle("t1_req0_packet");

    // Single-byte packets on req1..3; pointer now starts at 1.
    add_pkt(1, 1, 1'b0, 8'h00);
    add_pkt(1, 1, 1'b0, 8'h00);
    add_pkt(2, 1, 1'b0, 8'h00);
    add_pkt(2, 1, 1'b0, 8'h00);
    add_pkt(3, 1, 1'b0, 8'h00);
    plan();
    wait_idle("t2_round_robin");

    // Req3 arrives while req1 is mid-packet.
    add_pkt(1, 4, 1'b0, 8'h00);
    plan();
    base = rdy_cnt[1];
    n = 0;
    while (rdy_cnt[1] < base + 2 && n < BUDG) begin
      @(negedge clk);
      n++;
    end
    chk("t3_two_bytes_before_req3", 32'(rdy_cnt[1] - base), 32'd2);
    add_pkt(3, 2, 1'b0, 8'h00);
    plan();
    wait_idle("t3_no_interleave");

    // Transmitter never reports done: watchdog abort after first byte.
    hang = 1'b1;
    begin
      exp_t e;
      for (int i = 0; i < 2; i++) begin
        drv_byte[mdl_ptr].push_back(8'hA0 + 8'(i));
        drv_last[mdl_ptr].push_back(i == 1);
      end
      e.b = 8'hA0;
      e.r = 3'(mdl_ptr);
      sb.push_back(e);
      exp_to  = 1;
      mdl_ptr = (mdl_ptr + 1) % NR;
    end
    wait_idle("t4_timeout");
    hang = 1'b0;

    // Done held two cycles per byte.
    done_hold = 2;
    add_pkt(1, 2, 1'b0, 8'h00);
    plan();
    wait_idle("t5_long_done");

    // Reset while the transmitter is mid-byte.
    done_hold = 1;
    add_pkt(2, 3, 1'b0, 8'h00);
    plan();
    base = dv_count;
    n = 0;
    while (dv_count == base && n < BUDG) begin
      @(negedge clk);
      n++;
    end
    chk("t6_first_dv_seen", 32'(dv_count - base), 32'd1);
    repeat (10) @(negedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_grant", 32'(o_Grant), 32'd0);
    chk("t6_rst_dv", 32'(o_TX_DV), 32'd0);
    chk("t6_rst_busy", 32'(o_Busy), 32'd0);
    chk("t6_rst_txbyte", 32'(o_TX_Byte), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_idle("t6_after_reset");

    // Randomized phases.
    for (int p = 0; p < 5; p++) begin
      done_hold = $urandom_range(1, 3);
      for (int k = 0; k < NR; k++) begin
        int np;
        np = $urandom_range(0, 2);
        for (int j = 0; j < np; j++) add_pkt(k, $urandom_range(1, 3), 1'b0, 8'h00);
      end
      plan();
      wait_idle("rand_phase");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
